// File: rtl/datapath_operandos.sv
// Operand datapath: fetches A then B from a synchronous ROM and computes A+B, A-B or A*B into C.
// Fetches complete ROM_LAT+1 edges after acceptance; multiply takes B edges; held enables fire once.
module datapath_operandos #(
    parameter int W       = 8,
    parameter int AW      = 9,
    parameter int ROM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] Endereco,
    input  logic          EnA,
    input  logic          EnB,
    input  logic          EnC,
    input  logic          Op,
    input  logic          SEL,
    output logic [AW-1:0] rom_addr,
    input  logic [W-1:0]  rom_data,
    output logic          FimA,
    output logic          FimB,
    output logic          FimC,
    output logic [W-1:0]  B,
    output logic [W-1:0]  A_q,
    output logic [W-1:0]  Resultado,
    output logic          busy
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH_A,
        FETCH_B,
        MUL,
        WAIT_MUL_C
    } state_t;

    localparam logic [1:0]   LAT_LAST = 2'(ROM_LAT);
    localparam logic [W-1:0] ONE      = 1;
    localparam logic [W-1:0] ZERO     = 0;

    state_t         state, state_nx;
    logic           arm_a, arm_b, arm_c;
    logic [1:0]     wait_cnt;
    logic [W-1:0]   acc, cnt;
    logic           take_a, take_b, take_c, fetch_done;
    logic           ld_addr, ld_a, ld_b, mul_start, acc_clr, mul_step;
    logic           ld_c, c_from_acc, busy_set, busy_clr;

    // A request counts only once per enable assertion.
    assign take_a     = EnA & arm_a;
    assign take_b     = EnB & arm_b;
    assign take_c     = EnC & arm_c;
    assign fetch_done = (wait_cnt == LAT_LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        ld_addr    = 1'b0;
        ld_a       = 1'b0;
        ld_b       = 1'b0;
        mul_start  = 1'b0;
        acc_clr    = 1'b0;
        mul_step   = 1'b0;
        ld_c       = 1'b0;
        c_from_acc = 1'b0;
        busy_set   = 1'b0;
        busy_clr   = 1'b0;
        case (state)
            IDLE: begin
                if (take_a) begin
                    ld_addr  = 1'b1;
                    busy_set = 1'b1;
                    state_nx = FETCH_A;
                end else if (take_b) begin
                    ld_addr  = 1'b1;
                    busy_set = 1'b1;
                    state_nx = FETCH_B;
                end else if (take_c) begin
                    ld_c       = 1'b1;
                    c_from_acc = SEL;
                end
            end
            FETCH_A: begin
                if (fetch_done) begin
                    ld_a     = 1'b1;
                    busy_clr = 1'b1;
                    state_nx = IDLE;
                end
            end
            FETCH_B: begin
                if (fetch_done) begin
                    ld_b = 1'b1;
                    if (SEL && rom_data != ZERO) begin
                        mul_start = 1'b1;
                        state_nx  = MUL;
                    end else begin
                        acc_clr  = SEL;
                        busy_clr = 1'b1;
                        state_nx = IDLE;
                    end
                end
            end
            MUL: begin
                mul_step = 1'b1;
                if (cnt == ONE) begin
                    busy_clr = 1'b1;
                    state_nx = take_c ? WAIT_MUL_C : IDLE;
                end else if (take_c) begin
                    state_nx = WAIT_MUL_C;
                end
            end
            WAIT_MUL_C: begin
                // cnt reaches zero on the final add; C is latched one edge later.
                if (cnt == ZERO) begin
                    ld_c       = 1'b1;
                    c_from_acc = 1'b1;
                    state_nx   = IDLE;
                end else begin
                    mul_step = 1'b1;
                    busy_clr = (cnt == ONE);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr  <= '0;
            A_q       <= '0;
            B         <= '0;
            Resultado <= '0;
            acc       <= '0;
            cnt       <= '0;
            wait_cnt  <= '0;
            FimA      <= 1'b0;
            FimB      <= 1'b0;
            FimC      <= 1'b0;
            busy      <= 1'b0;
            arm_a     <= 1'b1;
            arm_b     <= 1'b1;
            arm_c     <= 1'b1;
        end else begin
            FimA <= ld_a;
            FimB <= ld_b;
            FimC <= ld_c;

            if (!EnA)      arm_a <= 1'b1;
            else if (ld_a) arm_a <= 1'b0;
            if (!EnB)      arm_b <= 1'b1;
            else if (ld_b) arm_b <= 1'b0;
            if (!EnC)      arm_c <= 1'b1;
            else if (ld_c) arm_c <= 1'b0;

            if (ld_addr) rom_addr <= Endereco;

            if (ld_addr)
                wait_cnt <= '0;
            else if (state == FETCH_A || state == FETCH_B)
                wait_cnt <= wait_cnt + 2'd1;

            if (ld_a) A_q <= rom_data;
            if (ld_b) B   <= rom_data;

            if (mul_start) begin
                acc <= '0;
                cnt <= rom_data;
            end else if (acc_clr) begin
                acc <= '0;
            end else if (mul_step) begin
                acc <= acc + A_q;
                cnt <= cnt - ONE;
            end

            if (ld_c) begin
                if (c_from_acc) Resultado <= acc;
                else if (Op)    Resultado <= A_q + B;
                else            Resultado <= A_q - B;
            end

            if (busy_set)      busy <= 1'b1;
            else if (busy_clr) busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_datapath_operandos.sv
// Bench for datapath_operandos: directed cases plus random transactions against a value-level model.
module tb_datapath_operandos;

    localparam int W       = 8;
    localparam int AW      = 9;
    localparam int ROM_LAT = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] Endereco = '0;
    logic          EnA = 1'b0, EnB = 1'b0, EnC = 1'b0, Op = 1'b0, SEL = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [W-1:0]  rom_data;
    logic          FimA, FimB, FimC, busy;
    logic [W-1:0]  B, A_q, Resultado;

    always #5 clk = ~clk;

    datapath_operandos #(.W(W), .AW(AW), .ROM_LAT(ROM_LAT)) dut (
        .clk(clk), .rst(rst), .Endereco(Endereco),
        .EnA(EnA), .EnB(EnB), .EnC(EnC), .Op(Op), .SEL(SEL),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .FimA(FimA), .FimB(FimB), .FimC(FimC),
        .B(B), .A_q(A_q), .Resultado(Resultado), .busy(busy)
    );

    logic [W-1:0] mem [0:511];
    always @(posedge clk) rom_data <= mem[rom_addr];

    int n_cmp = 0;
    int n_bad = 0;

    // Expected architectural state, updated at the edge each event is due.
    logic [W-1:0]  m_a, m_b, m_res, m_prod;
    logic [AW-1:0] m_addr;
    logic          m_busy;
    bit            mon_en = 1'b0;
    int            cnt_fa = 0, cnt_fb = 0, cnt_fc = 0;
    logic          pa = 1'b0, pb = 1'b0, pc = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_a = '0; m_b = '0; m_res = '0; m_prod = '0; m_addr = '0; m_busy = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("a_q", A_q, m_a);
            check("b", B, m_b);
            check("resultado", Resultado, m_res);
            check("busy", busy, m_busy);
            check("rom_addr", rom_addr, m_addr);
            check("fim_onehot", (32'(FimA) + 32'(FimB) + 32'(FimC)) <= 1, 1);
            check("fim_width", {29'b0, FimA & pa, FimB & pb, FimC & pc}, 0);
            cnt_fa += FimA;
            cnt_fb += FimB;
            cnt_fc += FimC;
            pa = FimA; pb = FimB; pc = FimC;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Fetch one operand; for a B load with SEL=1 also runs out the multiply.
    task automatic fetch(input bit is_b, input logic [AW-1:0] addr, input int gap,
                         input bit keep, input bit mul_c, input int abort_at);
        int lat;
        bit got;
        int fc0;
        int k;
        bit aborted;
        idle(gap);
        Endereco = addr;
        if (is_b) EnB = 1'b1; else EnA = 1'b1;
        @(posedge clk); #1;
        m_busy = 1'b1;
        m_addr = addr;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 8) begin
            @(posedge clk); #1;
            lat++;
            got = is_b ? FimB : FimA;
        end
        check(is_b ? "fimb_latency" : "fima_latency", lat, ROM_LAT + 1);
        if (!keep) begin
            if (is_b) EnB = 1'b0; else EnA = 1'b0;
        end
        if (!is_b) begin
            m_a = mem[addr];
            m_busy = 1'b0;
        end else begin
            m_b = mem[addr];
            if (SEL) m_prod = m_a * m_b;
            if (SEL && m_b != 0) begin
                fc0 = cnt_fc;
                if (mul_c) EnC = 1'b1;
                aborted = 1'b0;
                k = 1;
                while (!aborted && k <= int'(m_b)) begin
                    if (k == abort_at) begin
                        rst = 1'b1;
                        EnC = 1'b0;
                        @(posedge clk); #1;
                        model_reset();
                        rst = 1'b0;
                        aborted = 1'b1;
                    end else begin
                        @(posedge clk); #1;
                        k++;
                    end
                end
                check("no_early_fimc", cnt_fc, fc0);
                if (!aborted) begin
                    m_busy = 1'b0;
                    if (mul_c) begin
                        @(posedge clk); #1;
                        check("mul_fimc", FimC, 1);
                        m_res = m_prod;
                        EnC = 1'b0;
                    end
                end
            end else begin
                m_busy = 1'b0;
            end
        end
    endtask

    task automatic do_c(input int gap);
        idle(gap);
        EnC = 1'b1;
        @(posedge clk); #1;
        check("fimc", FimC, 1);
        if (SEL)     m_res = m_prod;
        else if (Op) m_res = m_a + m_b;
        else         m_res = m_a - m_b;
        EnC = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int fa0, fc0;
        logic [AW-1:0] aa, ab;
        bit mc;
        for (int i = 0; i < 512; i++) mem[i] = '0;
        model_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        mon_en = 1'b1;
        check("rst_fima", FimA, 0);
        check("rst_fimc", FimC, 0);
        check("rst_busy", busy, 0);
        check("rst_res", Resultado, 0);

        // Boot handshake
        SEL = 1'b0; Op = 1'b1;
        do_c(1);
        check("boot_res", Resultado, 0);

        // Add 20 + 7
        mem[1] = 8'd20; mem[0] = 8'd7;
        fetch(0, 9'd1, 1, 0, 0, 0);
        check("add_a", A_q, 20);
        fetch(1, 9'd0, 1, 0, 0, 0);
        check("add_b", B, 7);
        do_c(1);
        check("add_res", Resultado, 27);

        // Subtract wrap 5 - 9
        mem[2] = 8'd5; mem[3] = 8'd9; Op = 1'b0;
        fetch(0, 9'd2, 1, 0, 0, 0);
        fetch(1, 9'd3, 1, 0, 0, 0);
        do_c(1);
        check("sub_res", Resultado, 252);

        // Multiply 13 * 6 with EnC raised during MUL
        mem[4] = 8'd13; mem[5] = 8'd6; SEL = 1'b1;
        fetch(0, 9'd4, 1, 0, 0, 0);
        fetch(1, 9'd5, 1, 0, 1, 0);
        check("mul_res", Resultado, 78);

        // Multiply by zero
        mem[6] = 8'd0;
        fetch(1, 9'd6, 1, 0, 0, 0);
        do_c(1);
        check("mul0_res", Resultado, 0);

        // 255 * 2 wraps
        mem[7] = 8'd255; mem[8] = 8'd2;
        fetch(0, 9'd7, 1, 0, 0, 0);
        fetch(1, 9'd8, 1, 0, 0, 0);
        do_c(1);
        check("mulwrap_res", Resultado, 254);

        // Held EnA then a one-cycle drop
        SEL = 1'b0; Op = 1'b1;
        mem[9] = 8'h42; mem[10] = 8'h99;
        fa0 = cnt_fa;
        fetch(0, 9'd9, 1, 1, 0, 0);
        idle(7);
        check("held_one_fima", cnt_fa, fa0 + 1);
        EnA = 1'b0;
        fetch(0, 9'd10, 1, 0, 0, 0);
        check("rearm_a", A_q, 8'h99);

        // Simultaneous EnA and EnB
        mem[11] = 8'd3; mem[12] = 8'd4;
        idle(1);
        EnB = 1'b1;
        fetch(0, 9'd11, 0, 0, 0, 0);
        fetch(1, 9'd12, 0, 0, 0, 0);
        check("sim_a", A_q, 3);
        check("sim_b", B, 4);

        // Reset at MUL cycle 3
        SEL = 1'b1;
        mem[13] = 8'd13; mem[14] = 8'd6;
        fetch(0, 9'd13, 1, 0, 0, 0);
        fetch(1, 9'd14, 1, 0, 1, 3);
        fc0 = cnt_fc;
        idle(4);
        check("rst_no_fimc", cnt_fc, fc0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_a", A_q, 0);
        do_c(0);
        check("rst_after_c", Resultado, 0);

        // Random transactions
        for (int it = 0; it < 40; it++) begin
            aa = 9'($urandom_range(16, 511));
            ab = aa ^ 9'h100;
            SEL = 1'($urandom_range(0, 1));
            Op  = 1'($urandom_range(0, 1));
            mc  = 1'($urandom_range(0, 1));
            mem[aa] = 8'($urandom);
            mem[ab] = SEL ? 8'($urandom_range(0, 20)) : 8'($urandom);
            fetch(0, aa, 1, 0, 0, 0);
            fetch(1, ab, 1, 0, mc, 0);
            if (!(SEL && mc && mem[ab] != 0)) do_c(1);
        end

        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
